wb_uart_lite: RTL
=================

# wb_uart_lite

Wishbone-classic responder UART (8N1) for the rv32i SoC peripheral bus, sitting behind the Wishbone interconnect next to data memory and GPIO as an additional slave. It accepts single-beat register accesses from the core's Wishbone master and drives a serial TX line from an 8-entry FIFO. It also receives bytes into a one-deep holding register and raises a level interrupt on RX-valid or TX-empty.

## Interface
- BAUD_DIV_RESET, 16'd867: reset value of BAUDDIV; bit period = BAUDDIV+1 clocks (115200 baud at 100 MHz)
- TX_DEPTH, 8: TX FIFO entries, power of two, ≥2
- wb_clk_i  in  1  single clock; all logic on rising edge
- wb_rst_i  in  1  asynchronous, active-high reset
- wb_adr_i  in  8  byte address; decode on [4:2], [1:0] ignored
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte enables
- wb_we_i  in  1  1 = write
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_dat_o  out  32  read data, valid while wb_ack_o=1
- wb_ack_o  out  1  one-cycle acknowledge
- uart_rx_i  in  1  asynchronous serial input
- uart_tx_o  out  1  serial output, idle high
- irq_o  out  1  level interrupt

## Operation
- Register map (offset, function):
  - 0x00 TXDATA: W pushes wb_dat_i[7:0] when sel[0]=1; if FIFO full, byte dropped and TX_OVF set. Reads 0.
  - 0x04 RXDATA: R returns {rx_valid, 23'b0, rx_byte}; a read pops (clears rx_valid); rx_byte retains its value. Writes ignored.
  - 0x08 STATUS: bit0 tx_full, bit1 tx_empty, bit2 tx_busy (FSM≠IDLE), bit3 rx_valid, bit4 RX_OVR, bit5 FRAME_ERR, bit6 TX_OVF. Bits 4–6 are sticky and write-1-to-clear (sel[0]).
  - 0x0C BAUDDIV: [15:0] RW, honors sel[1:0]; upper bits read 0.
  - 0x10 IRQ_EN: [1:0] RW (bit0 rx_valid, bit1 tx_empty).
  - Unmapped offsets: acked, read 0, writes ignored.
- Bus: a request is sampled when cyc&stb&~ack. ack=1 in the following cycle with registered dat_o; ack always drops for ≥1 cycle between accesses. All side effects (push, pop, W1C, register write) commit at the sampling edge.
- TX FSM IDLE→START→DATA(8 bits, LSB first)→STOP→IDLE. In IDLE with FIFO non-empty: pop and enter START; uart_tx_o registered. Each state lasts BAUDDIV+1 cycles. Bit counter 0..7.
- RX: two-flop synchronizer (flops reset to 1). FSM IDLE→START→DATA→STOP.
  - IDLE→START on synced 0.
  - START: after (BAUDDIV>>1)+1 cycles re-sample; 1 → IDLE (glitch), 0 → DATA.
  - DATA: sample every BAUDDIV+1 cycles.
  - STOP: sample 1 → load rx_byte, set rx_valid (set RX_OVR first if already valid); sample 0 → FRAME_ERR set, byte discarded, rx_valid unchanged. Return to IDLE after the stop sample.
- irq_o = registered |(IRQ_EN & {tx_empty, rx_valid}).
- Simultaneous events:
  - FIFO push and TX pop in the same cycle: full is judged on pre-edge state, so a push to a full FIFO is dropped.
  - RXDATA read and RX load in the same cycle: the new byte loads, rx_valid stays 1, no RX_OVR.
  - W1C and a set of the same flag in the same cycle: set wins.
- BAUDDIV changes take effect immediately. Bit counters treat count ≥ BAUDDIV as terminal, so a mid-frame change may corrupt that frame but never hangs the block.

## Timing
- Reset values:
  - uart_tx_o=1, wb_ack_o=0, wb_dat_o=0, irq_o=0.
  - FIFO empty, both FSMs IDLE, sticky flags 0, rx_valid=0, rx_byte=0.
  - BAUDDIV=BAUD_DIV_RESET, IRQ_EN=0.
- Reset asserted mid-frame forces all of the above asynchronously; uart_tx_o goes high without waiting for a clock.
- Access latency: 1 cycle (ack in the cycle after sampling); back-to-back accesses every 2 cycles.
- TX latency: TXDATA write to empty FIFO with TX idle, sampled at edge E0 → pop at E1 → uart_tx_o low from E2. Frame = 10×(BAUDDIV+1) cycles; the next queued byte's start bit immediately follows the stop bit plus 1 IDLE cycle.
- RX: rx_valid rises 1 cycle after the stop sample. Sample instant is 2 synchronizer cycles after the line transition reference.

## Test plan
- Reset: pulse wb_rst_i → uart_tx_o=1, irq_o=0; STATUS reads 0x00000002; BAUDDIV reads 0x00000363.
- TX frame: BAUDDIV=3, write TXDATA=0xA5 → start bit begins 2 cycles after sampling. Line shows 4 cycles low, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 4 cycles high. STATUS bit1=1 after the frame.
- TX overflow: BAUDDIV=3, 10 back-to-back writes of 0x00..0x09 → 0x00–0x08 serialized in order, 0x09 dropped, STATUS bit6=1. Write STATUS=0x40 → bit6=0.
- RX + IRQ: IRQ_EN=1, BAUDDIV=3, drive an 8N1 frame 0x3C → irq_o=1, RXDATA reads 0x8000003C. Next read returns 0x0000003C and irq_o=0.
- RX errors:
  - Two frames 0x11, 0x22 with no read → RX_OVR=1, RXDATA=0x80000022.
  - A frame with stop=0 → FRAME_ERR=1, rx_valid unchanged.
  - A 1-cycle low glitch on uart_rx_i → no reception, no flags.
- Reset mid-frame: assert wb_rst_i during TX bit 3 with 3 bytes queued → uart_tx_o=1 asynchronously, STATUS=0x00000002 after release, no further bytes sent.

Source files
------------

// File: rtl/wb_uart_lite.sv
// wb_uart_lite: Wishbone-classic 8N1 UART responder with a TX FIFO,
// a one-deep RX holding register and a level interrupt.
module wb_uart_lite #(
    parameter logic [15:0] BAUD_DIV_RESET = 16'd867,
    parameter int          TX_DEPTH       = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [7:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    input  logic        uart_rx_i,
    output logic        uart_tx_o,
    output logic        irq_o
);

    localparam int AW = $clog2(TX_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(TX_DEPTH);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Bus decode
    logic       req;
    logic [2:0] reg_sel;
    logic       wr_tx;
    logic       rd_rx;
    logic       wr_stat;
    logic       wr_baud;
    logic       wr_ien;

    assign req     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign reg_sel = wb_adr_i[4:2];
    assign wr_tx   = req & wb_we_i & (reg_sel == 3'd0) & wb_sel_i[0];
    assign rd_rx   = req & ~wb_we_i & (reg_sel == 3'd1);
    assign wr_stat = req & wb_we_i & (reg_sel == 3'd2) & wb_sel_i[0];
    assign wr_baud = req & wb_we_i & (reg_sel == 3'd3);
    assign wr_ien  = req & wb_we_i & (reg_sel == 3'd4) & wb_sel_i[0];

    logic unused_bits;
    assign unused_bits = ^{wb_adr_i[7:5], wb_adr_i[1:0],
                           wb_dat_i[31:16], wb_sel_i[3:2]};

    // Control and status registers
    logic [15:0] baud_div;
    logic [1:0]  irq_en;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        rx_ovr;
    logic        frame_err;
    logic        tx_ovf;

    // TX FIFO
    logic [7:0]  fifo_mem [TX_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] tx_count;
    logic        tx_full;
    logic        tx_empty;
    logic        push;
    logic        pop;

    assign tx_count = wr_ptr - rd_ptr;
    assign tx_full  = (tx_count == FULL_CNT);
    assign tx_empty = (tx_count == '0);
    assign push     = wr_tx & ~tx_full;

    // TX FSM state
    tx_state_t   tx_state, tx_state_n;
    logic [15:0] tx_cnt, tx_cnt_n;
    logic [2:0]  tx_bit, tx_bit_n;
    logic [7:0]  tx_shift, tx_shift_n;
    logic        tx_line;
    logic        tx_tick;
    logic        tx_busy;

    assign tx_tick = (tx_cnt >= baud_div);
    assign tx_busy = (tx_state != TX_IDLE);
    assign pop     = (tx_state == TX_IDLE) & ~tx_empty;

    // RX path
    logic        rx_s1, rx_s2;
    rx_state_t   rx_state, rx_state_n;
    logic [15:0] rx_cnt, rx_cnt_n;
    logic [2:0]  rx_bit, rx_bit_n;
    logic [7:0]  rx_shift, rx_shift_n;
    logic        rx_load;
    logic        rx_ferr_set;
    logic [15:0] rx_half;

    assign rx_half = baud_div >> 1;

    // Read mux
    logic [31:0] rdata;
    logic [31:0] status;

    assign status = {25'd0, tx_ovf, frame_err, rx_ovr,
                     rx_valid, tx_busy, tx_empty, tx_full};

    always_comb begin
        rdata = 32'd0;
        unique case (reg_sel)
            3'd1:    rdata = {rx_valid, 23'd0, rx_byte};
            3'd2:    rdata = status;
            3'd3:    rdata = {16'd0, baud_div};
            3'd4:    rdata = {30'd0, irq_en};
            default: rdata = 32'd0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= 32'd0;
        end else begin
            wb_ack_o <= req;
            wb_dat_o <= (req && !wb_we_i) ? rdata : 32'd0;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            baud_div <= BAUD_DIV_RESET;
            irq_en   <= 2'b00;
        end else begin
            if (wr_baud && wb_sel_i[0]) baud_div[7:0]  <= wb_dat_i[7:0];
            if (wr_baud && wb_sel_i[1]) baud_div[15:8] <= wb_dat_i[15:8];
            if (wr_ien) irq_en <= wb_dat_i[1:0];
        end
    end

    // Set beats write-1-to-clear when both land on the same edge
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rx_valid  <= 1'b0;
            rx_byte   <= 8'd0;
            rx_ovr    <= 1'b0;
            frame_err <= 1'b0;
            tx_ovf    <= 1'b0;
            irq_o     <= 1'b0;
        end else begin
            rx_valid  <= rx_load | (rx_valid & ~rd_rx);
            if (rx_load) rx_byte <= rx_shift;
            rx_ovr    <= (rx_load & rx_valid & ~rd_rx) |
                         (rx_ovr & ~(wr_stat & wb_dat_i[4]));
            frame_err <= rx_ferr_set |
                         (frame_err & ~(wr_stat & wb_dat_i[5]));
            tx_ovf    <= (wr_tx & tx_full) |
                         (tx_ovf & ~(wr_stat & wb_dat_i[6]));
            irq_o     <= |(irq_en & {tx_empty, rx_valid});
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= wb_dat_i[7:0];
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            tx_state  <= TX_IDLE;
            tx_cnt    <= 16'd0;
            tx_bit    <= 3'd0;
            tx_shift  <= 8'd0;
            uart_tx_o <= 1'b1;
        end else begin
            tx_state  <= tx_state_n;
            tx_cnt    <= tx_cnt_n;
            tx_bit    <= tx_bit_n;
            tx_shift  <= tx_shift_n;
            uart_tx_o <= tx_line;
        end
    end

    // Count >= divisor ends a bit, so a shrinking divisor cannot stall
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + 16'd1;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_line    = 1'b1;
        unique case (tx_state)
            TX_IDLE: begin
                tx_cnt_n = 16'd0;
                if (pop) begin
                    tx_state_n = TX_START;
                    tx_shift_n = fifo_mem[rd_ptr[AW-1:0]];
                end
            end
            TX_START: begin
                tx_line = 1'b0;
                if (tx_tick) begin
                    tx_state_n = TX_DATA;
                    tx_cnt_n   = 16'd0;
                    tx_bit_n   = 3'd0;
                end
            end
            TX_DATA: begin
                tx_line = tx_shift[tx_bit];
                if (tx_tick) begin
                    tx_cnt_n = 16'd0;
                    tx_bit_n = tx_bit + 3'd1;
                    if (tx_bit == 3'd7) tx_state_n = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_tick) begin
                    tx_state_n = TX_IDLE;
                    tx_cnt_n   = 16'd0;
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= 16'd0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'd0;
        end else begin
            rx_s1    <= uart_rx_i;
            rx_s2    <= rx_s1;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end

    // Start bit is re-checked at mid-bit to reject line glitches
    always_comb begin
        rx_state_n  = rx_state;
        rx_cnt_n    = rx_cnt + 16'd1;
        rx_bit_n    = rx_bit;
        rx_shift_n  = rx_shift;
        rx_load     = 1'b0;
        rx_ferr_set = 1'b0;
        unique case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = 16'd0;
                if (!rx_s2) rx_state_n = RX_START;
            end
            RX_START: begin
                if (rx_cnt >= rx_half) begin
                    rx_cnt_n   = 16'd0;
                    rx_bit_n   = 3'd0;
                    rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt >= baud_div) begin
                    rx_cnt_n   = 16'd0;
                    rx_shift_n = {rx_s2, rx_shift[7:1]};
                    rx_bit_n   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt >= baud_div) begin
                    rx_cnt_n    = 16'd0;
                    rx_state_n  = RX_IDLE;
                    rx_load     = rx_s2;
                    rx_ferr_set = ~rx_s2;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

endmodule
